seg7_scan_ctrl: RTL

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display. It holds a 16-bit display word and cycles through its four nibbles at a programmable refresh rate. Each cycle it presents one nibble to the downstream 4-bit-to-7-segment decoder and drives the matching active-low digit enable. New words are committed only at frame boundaries, so the display never shows a torn value.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/refresh_tick_gen.sv | 34 +++
 rtl/seg7_scan_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and helpers for the 4-digit seven-segment scan controller.
// Nibble k of a display word belongs to digit k. Digit 0 is the rightmost digit.
package seg7_pkg;

    localparam int N_DIGITS         = 4;
    localparam int NIBBLE_W         = 4;
    localparam int DEFAULT_TICK_DIV = 100000;

    typedef logic [NIBBLE_W-1:0]            nibble_t;
    typedef logic [N_DIGITS*NIBBLE_W-1:0]   disp_word_t;
    typedef logic [$clog2(N_DIGITS)-1:0]    slot_idx_t;

    function automatic nibble_t get_nibble(input disp_word_t w, input slot_idx_t i);
        return w[{i, 2'b00} +: NIBBLE_W];
    endfunction

    // Digit i is a leading zero when it and every digit to its left are zero.
    // Digit 0 always stays lit so that a value of zero still shows "0".
    function automatic logic lz_blank(input disp_word_t w, input slot_idx_t i);
        logic res;
        case (i)
            2'd1:    res = (w[15:4]  == 12'h000);
            2'd2:    res = (w[15:8]  == 8'h00);
            2'd3:    res = (w[15:12] == 4'h0);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/refresh_tick_gen.sv
// Free-running prescaler that emits a one-cycle tick every TICK_DIV clocks, at its terminal count.
// Latency: the first tick arrives TICK_DIV cycles after reset release. No backpressure.
module refresh_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scans a 16-bit word over four common-anode digits. Words are committed only on frame wrap, so a frame is never torn.
// Latency: outputs update one clock after each tick. No backpressure: load is a strobe, and the last load before a wrap wins.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  blank_mask,
    input  logic        lz_suppress,
    output logic [3:0]  digit_bin,
    output logic [3:0]  an_n,
    output logic        frame_done
);

    logic       tick;
    logic       wrap;
    logic       blank;

    slot_idx_t  idx_q,        idx_d;
    disp_word_t disp_q,       disp_d;
    disp_word_t pend_q,       pend_d;
    logic       pend_v_q,     pend_v_d;
    nibble_t    digit_bin_q,  digit_bin_d;
    logic [3:0] an_n_q,       an_n_d;
    logic       frame_done_q, frame_done_d;

    refresh_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // idx starts at 3, so the first tick after reset is a frame wrap.
    assign wrap = tick && (idx_q == 2'd3);

    always_comb begin
        idx_d        = idx_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_v_d     = pend_v_q;
        digit_bin_d  = digit_bin_q;
        an_n_d       = an_n_q;
        frame_done_d = wrap;
        blank        = 1'b0;

        if (tick) begin
            idx_d = idx_q + 2'd1;
        end

        // A load that coincides with the wrap goes straight to disp and bypasses pend.
        if (wrap) begin
            pend_v_d = 1'b0;
            if (load) begin
                disp_d = data_in;
            end else if (pend_v_q) begin
                disp_d = pend_q;
            end
        end else if (load) begin
            pend_d   = data_in;
            pend_v_d = 1'b1;
        end

        if (tick) begin
            blank       = blank_mask[idx_d] | (lz_suppress & lz_blank(disp_d, idx_d));
            digit_bin_d = get_nibble(disp_d, idx_d);
            an_n_d      = 4'hF;
            if (!blank) begin
                an_n_d[idx_d] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= 2'd3;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            digit_bin_q  <= '0;
            an_n_q       <= 4'hF;
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            digit_bin_q  <= digit_bin_d;
            an_n_q       <= an_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digit_bin  = digit_bin_q;
    assign an_n       = an_n_q;
    assign frame_done = frame_done_q;

endmodule
